// File: rtl/intersection_scheduler.sv
// Two-road intersection right-of-way scheduler (NS main, EW side, optional walk phase); define PED_REQ_EN to enable pedestrians.
// Latency: demand latched one edge after sampling; lights are registered Moore outputs of the phase state.
// Backpressure: none; requests are level/pulse latches, dropped while their own phase is active.
module intersection_scheduler #(
    parameter int unsigned GREEN_T  = 4,
    parameter int unsigned YELLOW_T = 1,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned WALK_T   = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] ns_rgy,
    output logic [2:0] ew_rgy,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_NS_GREEN  = 3'd0,
        S_NS_YELLOW = 3'd1,
        S_CLEAR_A   = 3'd2,
        S_EW_GREEN  = 3'd3,
        S_EW_YELLOW = 3'd4,
        S_CLEAR_B   = 3'd5,
        S_WALK      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] ALLRED_C = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] WALK_C   = CNT_W'(WALK_T);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             side_pend_q, side_pend_d;
    logic             ped_pend_q, ped_pend_d;
    logic [2:0]       ns_q, ew_q;
    logic             walk_q;

    // {ns_rgy, ew_rgy, walk} for a given state
    function automatic logic [6:0] decode(input state_t s);
        case (s)
            S_NS_GREEN:  return {3'b010, 3'b100, 1'b0};
            S_NS_YELLOW: return {3'b001, 3'b100, 1'b0};
            S_EW_GREEN:  return {3'b100, 3'b010, 1'b0};
            S_EW_YELLOW: return {3'b100, 3'b001, 1'b0};
`ifdef PED_REQ_EN
            S_WALK:      return {3'b100, 3'b100, 1'b1};
`endif
            default:     return {3'b100, 3'b100, 1'b0};
        endcase
    endfunction

`ifndef PED_REQ_EN
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    always_comb begin
        state_d     = state_q;
        side_pend_d = (state_q == S_EW_GREEN) ? 1'b0 : (side_pend_q | side_req);
`ifdef PED_REQ_EN
        ped_pend_d  = (state_q == S_WALK) ? 1'b0 : (ped_pend_q | ped_req);
`else
        ped_pend_d  = 1'b0;
`endif
        case (state_q)
            S_NS_GREEN:  if (cnt_q == GREEN_C && (side_pend_q || ped_pend_q)) state_d = S_NS_YELLOW;
            S_NS_YELLOW: if (cnt_q == YELLOW_C) state_d = S_CLEAR_A;
`ifdef PED_REQ_EN
            // side demand wins; otherwise we only got here for a pedestrian
            S_CLEAR_A:   if (cnt_q == ALLRED_C) state_d = side_pend_q ? S_EW_GREEN : S_WALK;
            S_CLEAR_B:   if (cnt_q == ALLRED_C) state_d = ped_pend_q ? S_WALK : S_NS_GREEN;
`else
            S_CLEAR_A:   if (cnt_q == ALLRED_C) state_d = S_EW_GREEN;
            S_CLEAR_B:   if (cnt_q == ALLRED_C) state_d = S_NS_GREEN;
`endif
            S_EW_GREEN:  if (cnt_q == GREEN_C) state_d = S_EW_YELLOW;
            S_EW_YELLOW: if (cnt_q == YELLOW_C) state_d = S_CLEAR_B;
            S_WALK:      if (cnt_q == WALK_C) state_d = S_NS_GREEN;
            default:     state_d = S_NS_GREEN;
        endcase

        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == S_NS_GREEN && cnt_q == GREEN_C)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_NS_GREEN;
            cnt_q       <= '0;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            ns_q        <= 3'b010;
            ew_q        <= 3'b100;
            walk_q      <= 1'b0;
        end else begin
            state_q                <= state_d;
            cnt_q                  <= cnt_d;
            side_pend_q            <= side_pend_d;
            ped_pend_q             <= ped_pend_d;
            {ns_q, ew_q, walk_q}   <= decode(state_d);
        end
    end

    assign ns_rgy = ns_q;
    assign ew_rgy = ew_q;
    assign walk   = walk_q;
    assign phase  = state_q;

endmodule
